// File: rtl/lsu_queue.sv
// In-order load/store queue: buffers DEPTH tagged micro-ops and issues them one at a
// time over a level request / done memory port, returning single-cycle completions.
module lsu_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_ls,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   mem_re,
  output logic                   mem_wr,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_done,
  output logic                   out_valid,
  output logic                   out_ls,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic                  ls;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  entry_t entry_q [DEPTH];
  entry_t head_entry;

  state_e                 state_q,     state_d;
  logic [PTR_W-1:0]       head_q,      head_d;
  logic [PTR_W-1:0]       tail_q,      tail_d;
  logic [CNT_W-1:0]       count_q,     count_d;
  logic                   mem_re_q,    mem_re_d;
  logic                   mem_wr_q,    mem_wr_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_ls_q,    out_ls_d;
  logic [TAG_WIDTH-1:0]   out_tag_q,   out_tag_d;
  logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;

  logic push;
  logic pop;

  // A full queue refuses a push even when a completion frees a slot at the same edge.
  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == BUSY) && mem_done;
  assign head_entry = entry_q[head_q];

  // NOTE: queue storage has no reset; head, tail and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q[tail_q] <= '{ls: in_ls, addr: in_addr, data: in_data, tag: in_tag};
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    mem_re_d    = mem_re_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = 1'b0;
    out_ls_d    = out_ls_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;

    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          mem_re_d    = head_entry.ls;
          mem_wr_d    = !head_entry.ls;
          mem_addr_d  = head_entry.addr;
          mem_wdata_d = head_entry.ls ? '0 : head_entry.data;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_done) begin
          mem_re_d    = 1'b0;
          mem_wr_d    = 1'b0;
          out_valid_d = 1'b1;
          out_ls_d    = head_entry.ls;
          out_tag_d   = head_entry.tag;
          out_data_d  = head_entry.ls ? mem_rdata : '0;
          head_d      = head_q + PTR_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_re_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_ls_q    <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_re_q    <= mem_re_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_ls_q    <= out_ls_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end

  assign mem_re    = mem_re_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_valid = out_valid_q;
  assign out_ls    = out_ls_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_lsu_queue.sv
// Scoreboard bench for lsu_queue: a memory responder, a completion monitor and a
// directed-plus-random stimulus process, checked against an in-order memory model.
module tb_lsu_queue;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TW    = 6;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_ls;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_tag;
  logic          mem_re;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          out_valid;
  logic          out_ls;
  logic [TW-1:0] out_tag;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  lsu_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ls(in_ls), .in_addr(in_addr),
    .in_data(in_data), .in_tag(in_tag),
    .mem_re(mem_re), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .out_valid(out_valid), .out_ls(out_ls), .out_tag(out_tag), .out_data(out_data),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          ls;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic          ls;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } cmp_t;

  req_t          req_q[$];
  cmp_t          sb_q[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] phys_mem  [logic [AW-1:0]];

  int   errors = 0;
  int   checks = 0;
  int   acc_total = 0;
  int   cmp_total = 0;
  logic mem_hold = 1'b0;
  logic rand_delay = 1'b1;
  int   fixed_delay = 0;
  int   stray_req = 0;
  int   stray_ack = 0;
  int   last_gap = -1;

  logic resp_serving = 1'b0;
  int   resp_remaining = 0;
  int   resp_idle = 1000;
  req_t resp_cur;

  function automatic logic [DW-1:0] mem_default(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory side: serves one request at a time, applies stores when they complete.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        resp_serving = 1'b0;
        mem_done     = 1'b0;
        resp_idle    = 1000;
        req_q.delete();
      end else begin
        check("re_wr_exclusive", {mem_re, mem_wr} != 2'b11, 1);
        if (resp_serving && mem_done) begin
          resp_serving = 1'b0;
          mem_done     = 1'b0;
          if (!resp_cur.ls) phys_mem[resp_cur.addr] = resp_cur.wdata;
          check("req_drop", {mem_re, mem_wr}, 2'b00);
          resp_idle = 1;
        end else if (resp_serving) begin
          check("req_hold_re", mem_re, resp_cur.ls);
          check("req_hold_wr", mem_wr, !resp_cur.ls);
          check("req_hold_addr", mem_addr, resp_cur.addr);
          check("req_hold_wdata", mem_wdata, resp_cur.wdata);
          if (!mem_hold && resp_remaining > 0) resp_remaining--;
          mem_done = !mem_hold && (resp_remaining == 0);
        end else begin
          mem_done = 1'b0;
          if (mem_re || mem_wr) begin
            check("req_gap_min", resp_idle >= 1, 1);
            last_gap = resp_idle;
            if (req_q.size() == 0) begin
              fail("req_unexpected");
              resp_cur.ls    = mem_re;
              resp_cur.addr  = mem_addr;
              resp_cur.wdata = mem_wdata;
            end else begin
              resp_cur = req_q.pop_front();
              check("req_re", mem_re, resp_cur.ls);
              check("req_wr", mem_wr, !resp_cur.ls);
              check("req_addr", mem_addr, resp_cur.addr);
              check("req_wdata", mem_wdata, resp_cur.wdata);
            end
            resp_serving   = 1'b1;
            resp_remaining = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
            if (resp_cur.ls)
              mem_rdata = phys_mem.exists(resp_cur.addr) ? phys_mem[resp_cur.addr]
                                                         : mem_default(resp_cur.addr);
            else
              mem_rdata = $urandom;
            mem_done = !mem_hold && (resp_remaining == 0);
          end else begin
            if (resp_idle < 1000) resp_idle++;
            if (stray_req != stray_ack) begin
              mem_done = 1'b1;
              stray_ack++;
            end
          end
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every out_valid and tracks occupancy.
  initial begin
    cmp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sb_q.delete();
        cmp_total = acc_total;
      end else begin
        if (out_valid) begin
          cmp_total++;
          if (sb_q.size() == 0) begin
            fail("unexpected_completion");
          end else begin
            e = sb_q.pop_front();
            check("cmp_tag", out_tag, e.tag);
            check("cmp_ls", out_ls, e.ls);
            check("cmp_data", out_data, e.data);
          end
        end
        check("count", count, acc_total - cmp_total);
        check("in_ready", in_ready, (acc_total - cmp_total) != DEPTH);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the op is accepted.
  task automatic push(input logic ls, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [TW-1:0] tag);
    int   waited = 0;
    req_t r;
    cmp_t c;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      fail("push_timeout");
      return;
    end
    in_valid = 1'b1;
    in_ls    = ls;
    in_addr  = addr;
    in_data  = data;
    in_tag   = tag;
    r.ls    = ls;
    r.addr  = addr;
    r.wdata = ls ? '0 : data;
    c.ls    = ls;
    c.tag   = tag;
    if (ls) begin
      c.data = model_mem.exists(addr) ? model_mem[addr] : mem_default(addr);
    end else begin
      model_mem[addr] = data;
      c.data = '0;
    end
    req_q.push_back(r);
    sb_q.push_back(c);
    acc_total++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_rand(input logic [TW-1:0] tag);
    push(1'($urandom_range(0, 1)), rand_addr(), $urandom, tag);
  endtask

  task automatic drain();
    int waited = 0;
    while ((sb_q.size() != 0 || acc_total != cmp_total) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0) fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ls    = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    in_tag   = '0;
    phys_mem[32'h100]  = 32'hDEAD_BEEF;
    model_mem[32'h100] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_mem_re", mem_re, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ls", out_ls, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_data", out_data, 0);

    // Single load, memory answers in the first request cycle.
    rand_delay  = 1'b0;
    fixed_delay = 0;
    push(1'b1, 32'h100, $urandom, 6'd5);
    check("load_no_req_yet", mem_re, 0);
    @(negedge clk);
    check("load_re", mem_re, 1);
    check("load_wr", mem_wr, 0);
    check("load_addr", mem_addr, 32'h100);
    @(negedge clk);
    check("load_out_valid", out_valid, 1);
    check("load_out_tag", out_tag, 5);
    check("load_out_ls", out_ls, 1);
    check("load_out_data", out_data, 32'hDEAD_BEEF);
    check("load_re_drop", mem_re, 0);
    @(negedge clk);
    check("load_pulse_one", out_valid, 0);

    // Single store, done held off so the request is visible three cycles.
    fixed_delay = 2;
    push(1'b0, 32'h40, 32'h1234_5678, 6'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("store_wr", mem_wr, 1);
      check("store_re", mem_re, 0);
      check("store_addr", mem_addr, 32'h40);
      check("store_wdata", mem_wdata, 32'h1234_5678);
      check("store_no_cmp", out_valid, 0);
    end
    @(negedge clk);
    check("store_out_valid", out_valid, 1);
    check("store_out_tag", out_tag, 9);
    check("store_out_ls", out_ls, 0);
    check("store_out_data", out_data, 0);
    check("store_wr_drop", mem_wr, 0);
    @(negedge clk);

    // Fill while memory stalls, refuse a fifth op, then wrap the pointers.
    rand_delay = 1'b1;
    mem_hold   = 1'b1;
    for (int t = 1; t <= 4; t++) push_rand(TW'(t));
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_ls    = 1'b1;
    in_addr  = 32'h300;
    in_tag   = 6'd5;
    @(negedge clk);
    in_valid = 1'b0;
    check("full_refused_count", count, 4);
    mem_hold = 1'b0;
    for (int t = 5; t <= 8; t++) push_rand(TW'(t));
    drain();

    // Push on the same edge as a completion with two entries held.
    mem_hold = 1'b1;
    push_rand(6'd20);
    push_rand(6'd21);
    check("pp_count_before", count, 2);
    mem_hold = 1'b0;
    waited = 0;
    while (!mem_done && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!mem_done) fail("pp_done_timeout");
    mem_hold = 1'b1;
    push_rand(6'd22);
    check("pp_count_after", count, 2);
    check("pp_out_valid", out_valid, 1);
    check("pp_out_tag", out_tag, 20);
    mem_hold = 1'b0;
    drain();

    // Reset while busy with three queued entries.
    mem_hold = 1'b1;
    for (int t = 30; t < 33; t++) push_rand(TW'(t));
    check("mid_count_before", count, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_re", mem_re, 0);
    check("mid_rst_wr", mem_wr, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    model_mem = phys_mem;
    mem_hold  = 1'b0;
    stray_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_no_completion", out_valid, 0);
    end

    // Two loads back to back, each answered immediately.
    rand_delay  = 1'b0;
    fixed_delay = 0;
    push(1'b1, rand_addr(), $urandom, 6'd40);
    push(1'b1, rand_addr(), $urandom, 6'd41);
    drain();
    check("b2b_gap", last_gap, 1);

    // Randomised traffic.
    rand_delay = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) push_rand(TW'($urandom));
      else @(negedge clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
